// File: rtl/mix_col_seq_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helper for the column-mix sequencer.
package mix_col_seq_pkg;

    localparam int unsigned COL_W = 32;
    localparam int unsigned NCOL  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mix_col_seq_mix.sv
// Combinational AES MixColumns / InvMixColumns on one 32-bit column (row 0 in the MSB byte).
module mix_columns
    import mix_col_seq_pkg::*;
(
    input  logic [COL_W-1:0] col_i,
    input  logic             inv_en_i,
    output logic [COL_W-1:0] col_o
);

    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] b  [4];

    always_comb begin
        col_o = '0;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col_i[COL_W-1-8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
        for (int r = 0; r < 4; r++) begin
            // Inverse coefficients built from powers of x: 14 = 8^4^2, 11 = 8^2^1, 13 = 8^4^1, 9 = 8^1.
            if (inv_en_i) begin
                b[r] = (x8[r] ^ x4[r] ^ x2[r])
                     ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                     ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                     ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
            end else begin
                b[r] = x2[r] ^ x2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
            col_o[COL_W-1-8*r -: 8] = b[r];
        end
    end

endmodule

// File: rtl/mix_col_seq.sv
// Column-serial AES (Inv)MixColumns: one shared 32-bit datapath, four cycles per 128-bit state.
module mix_col_seq
    import mix_col_seq_pkg::*;
#(
    parameter bit SKIP_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCOL*COL_W-1:0] in_state,
    input  logic                  in_inv,
    input  logic                  in_skip,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCOL*COL_W-1:0] out_state,
    output logic                  busy
);

    state_e                  state_q, state_d;
    logic [1:0]              col_q, col_d;
    logic [NCOL*COL_W-1:0]   data_q, data_d;
    logic                    inv_q, inv_d;
    logic                    skip_q, skip_d;
    logic [NCOL*COL_W-1:0]   out_state_q, out_state_d;

    logic [COL_W-1:0]        col_raw;
    logic [COL_W-1:0]        col_mix;
    logic                    accept;

    mix_columns u_mix_columns (
        .col_i    (col_raw),
        .inv_en_i (inv_q),
        .col_o    (col_mix)
    );

    // Gated by rst_n so no handshake can be offered while reset is held.
    assign in_ready  = rst_n & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StBusy);
    assign out_state = out_state_q;

    always_comb begin
        col_raw = '0;
        for (int c = 0; c < NCOL; c++) begin
            if (col_q == 2'(c)) begin
                col_raw = data_q[COL_W*(NCOL-1-c) +: COL_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        data_d      = data_q;
        inv_d       = inv_q;
        skip_d      = skip_q;
        out_state_d = out_state_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                for (int c = 0; c < NCOL; c++) begin
                    if (col_q == 2'(c)) begin
                        out_state_d[COL_W*(NCOL-1-c) +: COL_W] = skip_q ? col_raw : col_mix;
                    end
                end
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = in_valid ? StBusy : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            data_d = in_state;
            inv_d  = in_inv;
            skip_d = in_skip & SKIP_EN;
            col_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            col_q       <= 2'd0;
            data_q      <= '0;
            inv_q       <= 1'b0;
            skip_q      <= 1'b0;
            out_state_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            data_q      <= data_d;
            inv_q       <= inv_d;
            skip_q      <= skip_d;
            out_state_q <= out_state_d;
        end
    end

endmodule

// File: tb/tb_mix_col_seq.sv
// Scoreboard bench for mix_col_seq: SKIP_EN=1 and SKIP_EN=0 instances driven in lockstep.
module tb_mix_col_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_state;
    logic         in_inv;
    logic         in_skip;
    logic         out_ready;
    logic         rand_rdy;

    logic         in_ready0, out_valid0, busy0;
    logic [127:0] out_state0;
    logic         in_ready1, out_valid1, busy1;
    logic [127:0] out_state1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [127:0] e0;
        logic [127:0] e1;
        int           acc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mix_col_seq #(.SKIP_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_state(in_state), .in_inv(in_inv), .in_skip(in_skip), .out_valid(out_valid0),
        .out_ready(out_ready), .out_state(out_state0), .busy(busy0)
    );

    mix_col_seq #(.SKIP_EN(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_state(in_state), .in_inv(in_inv), .in_skip(in_skip), .out_valid(out_valid1),
        .out_ready(out_ready), .out_state(out_state1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // General GF(2^8) product by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix product per column; row r uses coefficient m[(k - r) mod 4].
    function automatic logic [127:0] mix_ref(input logic [127:0] st, input logic inv,
                                             input logic skip);
        logic [7:0]   m [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (skip) return st;
        if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(st[127-32*c-8*k -: 8], m[(k-r+4)%4]);
                end
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer one state and wait (bounded) for acceptance; expectation enters the scoreboard then.
    task automatic send(input logic [127:0] st, input logic inv, input logic skip,
                        input logic [127:0] e0, input logic [127:0] e1);
        bit done;
        exp_t e;
        done = 0;
        @(posedge clk); #1;
        in_state = st; in_inv = inv; in_skip = skip; in_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (in_ready0 && in_ready1) begin
                e.e0 = e0; e.e1 = e1; e.acc = cyc + 1;
                sb.push_back(e);
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_state = rand128();
                in_inv   = 1'($urandom);
                in_skip  = 1'($urandom);
                done = 1;
            end
        end
        if (!done) chk("accept_timeout", 128'd0, 128'd1);
    endtask

    task automatic send_rand(input logic [127:0] st, input logic inv, input logic skip);
        send(st, inv, skip, mix_ref(st, inv, skip), mix_ref(st, inv, 1'b0));
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: latency at out_valid rise, stability under backpressure, data at handshake.
    logic         pv, pr;
    logic [127:0] ps;
    exp_t         got;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0; pr = 1'b0; ps = '0;
        end else begin
            if (out_valid0 && !pv) begin
                if (sb.size() == 0) chk("unexpected_out_valid", 128'd1, 128'd0);
                else chk("latency", 128'(cyc - sb[0].acc), 128'd4);
            end
            if (out_valid0 && pv && !pr) chk("stable_out_state", out_state0, ps);
            if (out_valid0 && out_ready && sb.size() != 0) begin
                got = sb.pop_front();
                chk("out_state_skip_en1", out_state0, got.e0);
                chk("out_valid_skip_en0", 128'(out_valid1), 128'd1);
                chk("out_state_skip_en0", out_state1, got.e1);
            end
            pv = out_valid0; pr = out_ready; ps = out_state0;
        end
    end

    logic [127:0] st_a, st_b;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_inv = 1'b0; in_skip = 1'b0;
        out_ready = 1'b0; rand_rdy = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready0), 128'd0);
        chk("rst_out_valid", 128'(out_valid0), 128'd0);
        chk("rst_busy", 128'(busy0), 128'd0);
        chk("rst_out_state", out_state0, 128'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready0), 128'd1);
        chk("post_rst_out_valid", 128'(out_valid0), 128'd0);
        chk("post_rst_busy", 128'(busy0), 128'd0);
        chk("post_rst_out_state", out_state0, 128'd0);

        out_ready = 1'b1;
        send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0,
             128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
             128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        send(128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1, 1'b0,
             128'hdb135345_f20a225c_d4d4d4d5_2d26314c,
             128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
        st_a = rand128();
        send(st_a, 1'b0, 1'b1, st_a, mix_ref(st_a, 1'b0, 1'b0));
        st_a = rand128();
        send(st_a, 1'b1, 1'b1, st_a, mix_ref(st_a, 1'b1, 1'b0));
        repeat (8) @(posedge clk);

        // Backpressure in DONE, then back-to-back acceptance on the releasing edge.
        out_ready = 1'b0;
        st_a = rand128();
        st_b = rand128();
        send_rand(st_a, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !out_valid0; i++) @(negedge clk);
        chk("bp_reach_done", 128'(out_valid0), 128'd1);
        @(posedge clk); #1;
        in_state = st_b; in_inv = 1'b1; in_skip = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 128'(in_ready0), 128'd0);
            chk("bp_out_valid", 128'(out_valid0), 128'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", 128'(in_ready0), 128'd1);
        got.e0 = mix_ref(st_b, 1'b1, 1'b0); got.e1 = got.e0; got.acc = cyc + 1;
        sb.push_back(got);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_busy", 128'(busy0), 128'd1);
        repeat (8) @(posedge clk);

        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send_rand(rand128(), 1'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
        chk("drain_empty", 128'(sb.size()), 128'd0);
        rand_rdy = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;

        // Reset during BUSY with col=2 aborts the transfer.
        send_rand(rand128(), 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #2;
        in_state = rand128(); in_inv = 1'b1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_state", out_state0, 128'd0);
        chk("midrst_busy", 128'(busy0), 128'd0);
        chk("midrst_out_valid", 128'(out_valid0), 128'd0);
        chk("midrst_in_ready", 128'(in_ready0), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_out_valid", 128'(out_valid0), 128'd0);
        end
        chk("midrst_idle_ready", 128'(in_ready0), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
